// File: rtl/scr_dma.sv
// Block COPY (memmove-safe) / FILL engine driving the scratch RAM's single port.
// Outputs decode straight from state flops so scr_wr is a bare register bit.
module scr_dma #(
  parameter int DW = 10,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  input  logic [DW-1:0] scr_rdata,
  output logic [AW-1:0] scr_addr,
  output logic          scr_wr,
  output logic [DW-1:0] scr_wdata,
  output logic          busy,
  output logic          done
);
  // Bit 2 is set only in the two writing states and drives scr_wr directly.
  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_RD   = 3'b001;
  localparam logic [2:0] S_DONE = 3'b010;
  localparam logic [2:0] S_WR   = 3'b100;
  localparam logic [2:0] S_FILL = 3'b110;

  localparam logic [AW:0]   MAX_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [2:0]    state;
  logic [AW-1:0] src_p, dst_p;
  logic [AW:0]   cnt;
  logic [DW-1:0] hold, fill_r;
  logic          back;

  logic [AW:0]   len_c;
  logic [AW-1:0] diff, last_off, step;
  logic          go_back;

  always_comb begin
    len_c    = (len > MAX_LEN) ? MAX_LEN : len;
    diff     = dst_addr - src_addr;
    last_off = AW'(len_c - CNT_ONE);
    // Destination starting inside the source window must be copied top-down.
    go_back  = (dst_addr != src_addr) && ({1'b0, diff} < len_c);
    step     = back ? {AW{1'b1}} : PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      src_p  <= '0;
      dst_p  <= '0;
      cnt    <= '0;
      hold   <= '0;
      fill_r <= '0;
      back   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt    <= len_c;
          fill_r <= fill_val;
          back   <= ~op & go_back;
          if (~op & go_back) begin
            src_p <= src_addr + last_off;
            dst_p <= dst_addr + last_off;
          end else begin
            src_p <= src_addr;
            dst_p <= dst_addr;
          end
          if (len_c == '0) state <= S_DONE;
          else if (op)     state <= S_FILL;
          else             state <= S_RD;
        end
        S_RD: begin
          hold  <= scr_rdata;
          state <= S_WR;
        end
        S_WR: begin
          src_p <= src_p + step;
          dst_p <= dst_p + step;
          cnt   <= cnt - CNT_ONE;
          state <= (cnt == CNT_ONE) ? S_DONE : S_RD;
        end
        S_FILL: begin
          dst_p <= dst_p + PTR_ONE;
          cnt   <= cnt - CNT_ONE;
          state <= (cnt == CNT_ONE) ? S_DONE : S_FILL;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign scr_wr    = state[2];
  assign scr_addr  = (state == S_RD) ? src_p : (state[2] ? dst_p : '0);
  assign scr_wdata = (state == S_WR) ? hold : ((state == S_FILL) ? fill_r : '0);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
endmodule

// File: tb/tb_scr_dma.sv
// Directed bench for scr_dma with a behavioural 256x10 scratch RAM.
module tb_scr_dma;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, op = 1'b0;
  logic [7:0] src_addr = '0, dst_addr = '0;
  logic [8:0] len = '0;
  logic [9:0] fill_val = '0;
  logic [9:0] scr_rdata, scr_wdata;
  logic [7:0] scr_addr;
  logic       scr_wr, busy, done;

  logic [9:0] mem [256];
  logic       ram_init = 1'b0;
  int tests = 0, failed = 0;

  scr_dma #(.DW(10), .AW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .fill_val(fill_val), .scr_rdata(scr_rdata),
    .scr_addr(scr_addr), .scr_wr(scr_wr), .scr_wdata(scr_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign scr_rdata = mem[scr_addr];
  always @(posedge clk) begin
    if (ram_init) for (int i = 0; i < 256; i++) mem[i] <= 10'(i);
    else if (scr_wr) mem[scr_addr] <= scr_wdata;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic init_ram();
    @(negedge clk); ram_init = 1'b1;
    @(negedge clk); ram_init = 1'b0;
  endtask

  task automatic kick(input logic o, input logic [7:0] s, input logic [7:0] d,
                      input logic [8:0] l, input logic [9:0] f);
    @(negedge clk);
    op = o; src_addr = s; dst_addr = d; len = l; fill_val = f; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  typedef struct {
    logic o; logic [7:0] s, d; logic [8:0] l; logic [9:0] f;
    int writes; logic [7:0] first; int done_cyc;
    logic [7:0] a0, a1, a2; logic [9:0] d0, d1, d2;
  } vec_t;

  vec_t v [10];
  int cyc, writes, first, busy_bad, done_cyc;

  initial begin
    // RAM starts as mem[i]=i before each vector; expectations are hand-derived from that.
    v[0] = '{1'b1, 8'h00, 8'h10, 9'd5,   10'h3A5, 5,   8'h10, 6,   8'h14, 8'h15, 8'h0F, 10'h3A5, 10'h015, 10'h00F};
    v[1] = '{1'b0, 8'h20, 8'h40, 9'd4,   10'h000, 4,   8'h40, 9,   8'h40, 8'h43, 8'h44, 10'h020, 10'h023, 10'h044};
    v[2] = '{1'b0, 8'h00, 8'h02, 9'd4,   10'h000, 4,   8'h05, 9,   8'h02, 8'h05, 8'h01, 10'h000, 10'h003, 10'h001};
    v[3] = '{1'b0, 8'h02, 8'h00, 9'd4,   10'h000, 4,   8'h00, 9,   8'h00, 8'h03, 8'h04, 10'h002, 10'h005, 10'h004};
    v[4] = '{1'b1, 8'h00, 8'hFE, 9'd4,   10'h155, 4,   8'hFE, 5,   8'hFF, 8'h01, 8'h02, 10'h155, 10'h155, 10'h002};
    v[5] = '{1'b0, 8'h05, 8'h09, 9'd0,   10'h000, 0,   8'h00, 1,   8'h09, 8'h0A, 8'h05, 10'h009, 10'h00A, 10'h005};
    v[6] = '{1'b1, 8'h00, 8'h80, 9'd300, 10'h2AA, 256, 8'h80, 257, 8'h7F, 8'h00, 8'h80, 10'h2AA, 10'h2AA, 10'h2AA};
    v[7] = '{1'b0, 8'hFE, 8'h10, 9'd4,   10'h000, 4,   8'h10, 9,   8'h10, 8'h12, 8'h13, 10'h0FE, 10'h000, 10'h001};
    v[8] = '{1'b0, 8'h30, 8'h30, 9'd3,   10'h000, 3,   8'h30, 7,   8'h30, 8'h32, 8'h33, 10'h030, 10'h032, 10'h033};
    v[9] = '{1'b0, 8'hFE, 8'hFF, 9'd3,   10'h000, 3,   8'h01, 7,   8'h01, 8'hFF, 8'h00, 10'h000, 10'h0FE, 10'h0FF};

    #3;
    chk("rst_scr_wr", scr_wr, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_addr", scr_addr, 0); chk("rst_wdata", scr_wdata, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      init_ram();
      kick(v[i].o, v[i].s, v[i].d, v[i].l, v[i].f);
      cyc = 0; writes = 0; first = -1; busy_bad = 0; done_cyc = -1;
      while (done_cyc < 0 && cyc < 600) begin
        @(negedge clk); cyc++;
        if (scr_wr) begin
          if (writes == 0) first = scr_addr;
          writes++;
        end
        if (!busy) busy_bad++;
        if (done) done_cyc = cyc;
      end
      chk($sformatf("v%0d_done_cycle", i), done_cyc, v[i].done_cyc);
      chk($sformatf("v%0d_writes", i), writes, v[i].writes);
      chk($sformatf("v%0d_busy_gaps", i), busy_bad, 0);
      if (v[i].writes > 0) chk($sformatf("v%0d_first_addr", i), first, v[i].first);
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
      chk($sformatf("v%0d_idle_done", i), done, 0);
      chk($sformatf("v%0d_mem0", i), mem[v[i].a0], v[i].d0);
      chk($sformatf("v%0d_mem1", i), mem[v[i].a1], v[i].d1);
      chk($sformatf("v%0d_mem2", i), mem[v[i].a2], v[i].d2);
    end

    // Abort: reset during the 3rd write of a len=8 COPY.
    init_ram();
    kick(1'b0, 8'h50, 8'h60, 9'd8, 10'h000);
    writes = 0; cyc = 0;
    while (writes < 3 && cyc < 50) begin
      @(negedge clk); cyc++;
      if (scr_wr) writes++;
    end
    chk("abort_reached_wr3", writes, 3);
    rst = 1'b1; #1;
    chk("abort_scr_wr", scr_wr, 0); chk("abort_busy", busy, 0);
    chk("abort_addr", scr_addr, 0); chk("abort_wdata", scr_wdata, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0; @(negedge clk);
    chk("abort_mem60", mem[8'h60], 10'h050);
    chk("abort_mem61", mem[8'h61], 10'h051);
    chk("abort_mem62", mem[8'h62], 10'h062);
    chk("abort_mem67", mem[8'h67], 10'h067);

    // Starts while busy and in DONE are ignored; operand changes mid-transfer have no effect.
    init_ram();
    kick(1'b0, 8'h20, 8'h40, 9'd4, 10'h000);
    cyc = 0; done_cyc = -1;
    while (done_cyc < 0 && cyc < 50) begin
      @(negedge clk); cyc++;
      if (cyc == 3) begin
        start = 1'b1; op = 1'b1; src_addr = 8'h00; dst_addr = 8'h41; len = 9'd2; fill_val = 10'h3FF;
      end else if (done) begin
        done_cyc = cyc; start = 1'b1;
      end else start = 1'b0;
    end
    @(negedge clk); start = 1'b0;
    chk("ign_done_cycle", done_cyc, 9);
    chk("ign_after_done_busy", busy, 0);
    @(negedge clk);
    chk("ign_still_idle", busy, 0);
    chk("ign_mem40", mem[8'h40], 10'h020);
    chk("ign_mem41", mem[8'h41], 10'h021);
    chk("ign_mem42", mem[8'h42], 10'h022);
    chk("ign_mem43", mem[8'h43], 10'h023);
    chk("ign_mem44", mem[8'h44], 10'h044);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
